// File: rtl/drone_spi_pkg.sv
// Shared definitions for the drone SPI responder path: FSM states,
// responder indices and the byte driven when no responder owns the bus.
package drone_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_HOLD,
        ST_RELEASE
    } arb_state_t;

    localparam int unsigned RSP_RECEIVER  = 0;
    localparam int unsigned RSP_ALTIMETER = 1;
    localparam int unsigned RSP_GPS       = 2;

    localparam logic [7:0] SPI_IDLE_FILL = 8'hFF;

endpackage

// File: rtl/spi_response_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping modulo NUM_REQ, returned one-hot with a valid flag.
module rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_response_arbiter.sv
// Shares the SPI-slave transmit path among NUM_REQ responder FSMs with
// round-robin grants held for a whole transaction, plus watchdog and deselect abort.
module spi_response_arbiter
    import drone_spi_pkg::*;
#(
    parameter int unsigned       NUM_REQ   = 3,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0] IDLE_FILL = SPI_IDLE_FILL
) (
    input  logic                      clk_system,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        done,
    input  logic [NUM_REQ*DATA_W-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_latch,
    input  logic                      spi_new_data,
    input  logic                      slave_select_n,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         spi_wr_data,
    output logic                      spi_latch,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned      IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned      WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_t         state, state_nx;
    logic [NUM_REQ-1:0] grant_nx;
    logic [IDX_W-1:0]   grant_idx, grant_idx_nx;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
    logic [WDOG_W-1:0]  wdog, wdog_nx;
    logic               timeout_err_nx;
    logic               ss_prev;
    logic               ss_rise;
    logic               done_g;
    logic               hold_active;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    assign ss_rise = ~ss_prev & slave_select_n;
    assign done_g  = done[grant_idx];

    always_comb begin
        state_nx       = state;
        grant_nx       = grant;
        grant_idx_nx   = grant_idx;
        rr_ptr_nx      = rr_ptr;
        wdog_nx        = wdog;
        timeout_err_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx     = ST_GRANT;
                    grant_nx     = pick;
                    grant_idx_nx = pick_idx;
                end
            end
            ST_GRANT: begin
                wdog_nx  = '0;
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (spi_new_data)    wdog_nx = '0;
                else if (wdog != '1) wdog_nx = wdog + 1'b1;
                // done beats deselect beats watchdog; only the watchdog flags an error
                if (done_g || ss_rise || (wdog == WDOG_LAST)) begin
                    state_nx       = ST_RELEASE;
                    grant_nx       = '0;
                    timeout_err_nx = !done_g && !ss_rise;
                end
            end
            ST_RELEASE: begin
                rr_ptr_nx = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_system) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            rr_ptr      <= IDX_W'(RSP_RECEIVER);
            wdog        <= '0;
            timeout_err <= 1'b0;
            ss_prev     <= 1'b1;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            grant_idx   <= grant_idx_nx;
            rr_ptr      <= rr_ptr_nx;
            wdog        <= wdog_nx;
            timeout_err <= timeout_err_nx;
            ss_prev     <= slave_select_n;
        end
    end

    // Gating with reset keeps a held responder latch from reaching the slave during reset
    assign hold_active = (state == ST_HOLD) && !reset;
    assign spi_wr_data = hold_active ? rsp_data[grant_idx*DATA_W +: DATA_W] : IDLE_FILL;
    assign spi_latch   = hold_active & rsp_latch[grant_idx];
    assign busy        = (state == ST_GRANT) || (state == ST_HOLD);

endmodule

// File: tb/tb_spi_response_arbiter.sv
// Directed self-checking bench for spi_response_arbiter with a short watchdog.
module tb_spi_response_arbiter;

    localparam int unsigned TO = 16;

    logic       clk_system = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] done;
    logic [23:0] rsp_data;
    logic [2:0] rsp_latch;
    logic       spi_new_data;
    logic       slave_select_n;
    logic [2:0] grant;
    logic [7:0] spi_wr_data;
    logic       spi_latch;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    spi_response_arbiter #(
        .NUM_REQ   (3),
        .DATA_W    (8),
        .TIMEOUT   (TO),
        .IDLE_FILL (8'hFF)
    ) dut (
        .clk_system     (clk_system),
        .reset          (reset),
        .req            (req),
        .done           (done),
        .rsp_data       (rsp_data),
        .rsp_latch      (rsp_latch),
        .spi_new_data   (spi_new_data),
        .slave_select_n (slave_select_n),
        .grant          (grant),
        .spi_wr_data    (spi_wr_data),
        .spi_latch      (spi_latch),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk_system = ~clk_system;

    task automatic tick();
        @(posedge clk_system);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [2:0] g);
        case (g)
            3'b001:  return 8'hA5;
            3'b010:  return 8'h5A;
            3'b100:  return 8'h3C;
            default: return 8'hFF;
        endcase
    endfunction

    // Entered in IDLE with req driven; leaves the DUT in IDLE after the release.
    task automatic xact(input logic [2:0] g, input string tag);
        tick();
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_data"}, 32'(spi_wr_data), 32'(exp_data(g)));
        chk({tag, "_latch"}, 32'(spi_latch), 32'((g & rsp_latch) != 3'b000));
        tick();
        tick();
        done = g;
        tick();
        done = '0;
        chk({tag, "_rel_grant"}, 32'(grant), 32'd0);
        chk({tag, "_rel_data"}, 32'(spi_wr_data), 32'hFF);
        chk({tag, "_rel_terr"}, 32'(timeout_err), 32'd0);
        tick();
        chk({tag, "_gap_grant"}, 32'(grant), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        reset          = 1'b1;
        req            = '0;
        done           = '0;
        rsp_data       = {8'h3C, 8'h5A, 8'hA5};
        rsp_latch      = '0;
        spi_new_data   = 1'b0;
        slave_select_n = 1'b0;

        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_latch", 32'(spi_latch), 32'd0);
        chk("rst_data", 32'(spi_wr_data), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick();

        // Single receiver transaction; rr_ptr moves to 1 afterwards.
        req       = 3'b001;
        rsp_latch = 3'b001;
        xact(3'b001, "t1");
        req = '0;
        tick();

        // Reset during altimeter HOLD with its latch high.
        req       = 3'b010;
        rsp_latch = 3'b010;
        tick();
        chk("t5_grant", 32'(grant), 32'b010);
        tick();
        chk("t5_hold_latch", 32'(spi_latch), 32'd1);
        reset = 1'b1;
        req   = 3'b111;
        tick();
        reset = 1'b0;
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_latch", 32'(spi_latch), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);

        // All three requesting: rotation restarts at the receiver.
        rsp_latch = 3'b101;
        xact(3'b001, "t2a");
        xact(3'b010, "t2b");
        xact(3'b100, "t2c");
        xact(3'b001, "t2d");

        // GPS stalls: watchdog fires TO cycles into HOLD.
        req = 3'b100;
        tick();
        chk("t3_grant", 32'(grant), 32'b100);
        tick();
        for (int i = 1; i < int'(TO); i++) begin
            tick();
            if (i == int'(TO) - 1) begin
                chk("t3_last_hold_grant", 32'(grant), 32'b100);
                chk("t3_last_hold_terr", 32'(timeout_err), 32'd0);
            end
        end
        tick();
        chk("t3_terr_pulse", 32'(timeout_err), 32'd1);
        chk("t3_rel_grant", 32'(grant), 32'd0);
        tick();
        chk("t3_terr_clear", 32'(timeout_err), 32'd0);

        // Receiver granted from rr_ptr=0; spi_new_data restarts the watchdog,
        // then done coincides with the watchdog limit.
        req = 3'b011;
        tick();
        chk("t6_grant", 32'(grant), 32'b001);
        tick();
        for (int i = 0; i < 5; i++) tick();
        spi_new_data = 1'b1;
        tick();
        spi_new_data = 1'b0;
        for (int i = 0; i < int'(TO) - 2; i++) tick();
        chk("t6_wdog_cleared_grant", 32'(grant), 32'b001);
        chk("t6_wdog_cleared_terr", 32'(timeout_err), 32'd0);
        tick();
        done = 3'b001;
        tick();
        done = '0;
        chk("t6_rel_terr", 32'(timeout_err), 32'd0);
        chk("t6_rel_grant", 32'(grant), 32'd0);
        tick();
        tick();
        chk("t6_next_grant", 32'(grant), 32'b010);

        // Altimeter held: foreign done ignored, deselect rising aborts.
        req = '0;
        tick();
        chk("t4_data", 32'(spi_wr_data), 32'h5A);
        done = 3'b001;
        tick();
        done = '0;
        chk("t4_foreign_done_grant", 32'(grant), 32'b010);
        chk("t4_foreign_done_busy", 32'(busy), 32'd1);
        slave_select_n = 1'b1;
        tick();
        slave_select_n = 1'b0;
        chk("t4_rel_grant", 32'(grant), 32'd0);
        chk("t4_rel_data", 32'(spi_wr_data), 32'hFF);
        chk("t4_rel_terr", 32'(timeout_err), 32'd0);
        tick();
        chk("t4_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
